// File: rtl/asm_ex_arbiter_if.sv
// Signal bundle between asm_ex_arbiter, its two requesters and the asm_ex datapath.
// The arbiter attaches through the slave modport; the environment drives the master side.
interface asm_ex_arbiter_if;
  logic [1:0] req;
  logic [3:0] din0;
  logic [3:0] din1;
  logic [1:0] gnt;
  logic [1:0] done;
  logic       err;
  logic [6:0] result;
  logic       busy;
  logic       asm_start;
  logic [3:0] asm_din;
  logic [6:0] asm_dout;
  logic       asm_done_tick;

  modport slave (
    input  req, din0, din1, asm_dout, asm_done_tick,
    output gnt, done, err, result, busy, asm_start, asm_din
  );

  modport master (
    output req, din0, din1, asm_dout, asm_done_tick,
    input  gnt, done, err, result, busy, asm_start, asm_din
  );
endinterface

// File: rtl/asm_ex_arbiter.sv
// Two-requester round-robin front end for the asm_ex datapath: grants one requester,
// issues a start pulse, waits for completion or timeout, then pulses done to the winner.
module asm_ex_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  asm_ex_arbiter_if.slave bus
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       last_served;  // index of the requester that most recently reached DONE
  logic       winner;

  // NOTE: every variable written in always_comb gets a default first, so no path
  // through the block can leave it unassigned and infer a latch.
  always_comb begin
    winner = 1'b0;
    if (bus.req == 2'b11) begin
      winner = ~last_served;
    end else if (bus.req[1]) begin
      winner = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      last_served   <= 1'b1;
      bus.gnt       <= '0;
      bus.done      <= '0;
      bus.err       <= 1'b0;
      bus.result    <= '0;
      bus.busy      <= 1'b0;
      bus.asm_start <= 1'b0;
      bus.asm_din   <= '0;
    end else begin
      // Pulse outputs are single-cycle unless a state below re-asserts them.
      bus.done      <= '0;
      bus.err       <= 1'b0;
      bus.asm_start <= 1'b0;

      unique case (state)
        IDLE: begin
          if (bus.req != 2'b00) begin
            bus.gnt       <= winner ? 2'b10 : 2'b01;
            bus.asm_din   <= winner ? bus.din1 : bus.din0;
            bus.asm_start <= 1'b1;
            bus.busy      <= 1'b1;
            state         <= ISSUE;
          end
        end

        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end

        WAIT: begin
          // A completion tick takes priority over a simultaneous timeout.
          if (bus.asm_done_tick) begin
            bus.result  <= bus.asm_dout;
            bus.done    <= bus.gnt;
            last_served <= bus.gnt[1];
            state       <= DONE;
          end else if (cnt == TIMEOUT_CNT) begin
            bus.done    <= bus.gnt;
            bus.err     <= 1'b1;
            last_served <= bus.gnt[1];
            state       <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        DONE: begin
          bus.gnt  <= '0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_asm_ex_arbiter.sv
// Randomized scoreboard bench for asm_ex_arbiter: the driver predicts each transaction
// from the arbitration rules and queues it; a monitor checks the DUT cycle by cycle.
module tb_asm_ex_arbiter;

  localparam int TO = 8;

  typedef struct {
    logic [1:0] gnt;
    logic [3:0] din;
    logic       err;
    logic [6:0] result;
    int         lat;     // cycles from the visible start pulse to the visible done pulse
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  asm_ex_arbiter_if bus ();

  asm_ex_arbiter #(.TIMEOUT(TO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int         vectors     = 0;
  int         miscompares = 0;
  exp_t       exp_q[$];
  logic       last_served;    // reference: requester served most recently
  logic [6:0] model_result;   // reference: value result should hold

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},       32'(bus.gnt),       0);
    check({tag, "_done"},      32'(bus.done),      0);
    check({tag, "_err"},       32'(bus.err),       0);
    check({tag, "_busy"},      32'(bus.busy),      0);
    check({tag, "_asm_start"}, 32'(bus.asm_start), 0);
    check({tag, "_asm_din"},   32'(bus.asm_din),   0);
    check({tag, "_result"},    32'(bus.result),    0);
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge clk);
      bus.asm_done_tick = 1'b0;
      seen = bus.asm_start;
    end
    check("start_seen", 32'(seen), 1);
  endtask

  // One full transaction. j = WAIT cycle on which the datapath ticks (1-based);
  // j > TO+1 means the datapath stays silent and the timeout fires.
  task automatic run_txn(input logic [1:0] r, input logic [3:0] d0, input logic [3:0] d1,
                         input int j, input logic [6:0] dv, input bit perturb, input int gap);
    exp_t e;
    logic w;
    int   e_end;
    bit   seen;

    bus.req = 2'b00;
    for (int g = 0; g < gap; g++) begin
      bus.asm_done_tick = 1'($urandom_range(0, 1));  // stray ticks outside WAIT
      bus.asm_dout      = 7'($urandom);
      @(negedge clk);
    end
    bus.asm_done_tick = 1'b0;
    bus.req  = r;
    bus.din0 = d0;
    bus.din1 = d1;

    if (r == 2'b11) w = (last_served == 1'b0) ? 1'b1 : 1'b0;
    else            w = (r == 2'b10);
    last_served = w;

    e.gnt = w ? 2'b10 : 2'b01;
    e.din = w ? d1 : d0;
    e.err = (j > TO + 1);
    if (!e.err) model_result = dv;
    e.result = model_result;
    e_end    = ((j < TO + 1) ? j : TO + 1) + 1;
    e.lat    = e_end;
    exp_q.push_back(e);

    wait_start(seen);
    if (!seen) return;

    for (int c = 1; c <= e_end; c++) begin
      @(negedge clk);
      bus.asm_done_tick = (c == j);
      bus.asm_dout      = (c == j) ? dv : 7'($urandom);
      if (perturb && c == 1) begin
        bus.req  = 2'b00;
        bus.din0 = d0 ^ 4'h9;
        bus.din1 = d1 ^ 4'h9;
      end
    end
  endtask

  task automatic reset_mid_wait(input logic [3:0] d0);
    exp_t e;
    bit   seen;

    bus.req           = 2'b01;
    bus.din0          = d0;
    bus.asm_done_tick = 1'b0;
    e.gnt    = 2'b01;
    e.din    = d0;
    e.err    = 1'b0;
    e.result = model_result;
    e.lat    = 0;
    exp_q.push_back(e);

    wait_start(seen);
    bus.req = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("mid_rst");
    last_served  = 1'b1;
    model_result = '0;

    bus.asm_done_tick = 1'b1;
    bus.asm_dout      = 7'h7f;
    @(negedge clk);
    bus.asm_done_tick = 1'b0;
    check("stray_result", 32'(bus.result), 0);
    check("stray_done",   32'(bus.done),   0);
  endtask

  // Monitor: samples just after each rising edge.
  exp_t       cur;
  bit         in_txn     = 1'b0;
  int         cyc        = 0;
  logic [6:0] cur_result = '0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        in_txn     = 1'b0;
        cur_result = '0;
      end else if (bus.asm_start && !in_txn) begin
        check("start_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          cur    = exp_q.pop_front();
          in_txn = 1'b1;
          cyc    = 0;
          check("start_gnt",  32'(bus.gnt),     32'(cur.gnt));
          check("start_din",  32'(bus.asm_din), 32'(cur.din));
          check("start_busy", 32'(bus.busy),    1);
        end
      end else if (in_txn) begin
        cyc++;
        check("hold_gnt",   32'(bus.gnt),       32'(cur.gnt));
        check("hold_din",   32'(bus.asm_din),   32'(cur.din));
        check("hold_start", 32'(bus.asm_start), 0);
        check("hold_busy",  32'(bus.busy),      1);
        if (bus.done != 2'b00) begin
          check("done_vec",     32'(bus.done),   32'(cur.gnt));
          check("done_err",     32'(bus.err),    32'(cur.err));
          check("done_result",  32'(bus.result), 32'(cur.result));
          check("done_latency", 32'(cyc),        32'(cur.lat));
          cur_result = cur.result;
          in_txn     = 1'b0;
        end else begin
          check("wait_err",    32'(bus.err),    0);
          check("wait_result", 32'(bus.result), 32'(cur_result));
          if (cyc > TO + 4) begin
            check("done_timeout", 32'(cyc), 32'(cur.lat));
            in_txn = 1'b0;
          end
        end
      end else begin
        check("idle_gnt",    32'(bus.gnt),    0);
        check("idle_done",   32'(bus.done),   0);
        check("idle_err",    32'(bus.err),    0);
        check("idle_busy",   32'(bus.busy),   0);
        check("idle_result", 32'(bus.result), 32'(cur_result));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req           = 2'b00;
    bus.din0          = '0;
    bus.din1          = '0;
    bus.asm_dout      = '0;
    bus.asm_done_tick = 1'b0;
    last_served       = 1'b1;
    model_result      = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b0;

    // Tie from reset: 0, then 1, then 0 again.
    run_txn(2'b11, 4'h1, 4'h2, 2, 7'h11, 1'b0, 0);
    run_txn(2'b11, 4'h3, 4'h4, 1, 7'h22, 1'b0, 0);
    run_txn(2'b11, 4'h5, 4'h6, 5, 7'h33, 1'b0, 0);
    // Single request, answer after 3 silent WAIT cycles.
    run_txn(2'b01, 4'h5, 4'h0, 4, 7'h19, 1'b0, 1);
    // Silent datapath: timeout, result unchanged.
    run_txn(2'b10, 4'h9, 4'h7, TO + 2, 7'h55, 1'b0, 1);
    // Tick coincides with counter == TIMEOUT.
    run_txn(2'b01, 4'h2, 4'h8, TO + 1, 7'h66, 1'b0, 1);
    // Operand 3 -> A and req dropped during WAIT.
    run_txn(2'b01, 4'h3, 4'h0, 3, 7'h2a, 1'b1, 0);
    reset_mid_wait(4'hc);

    for (int n = 0; n < 60; n++) begin
      run_txn(2'($urandom_range(1, 3)), 4'($urandom), 4'($urandom),
              $urandom_range(1, TO + 2), 7'($urandom),
              ($urandom_range(0, 3) == 0), $urandom_range(0, 2));
    end

    bus.req = 2'b00;
    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/asm_ex_arbiter.md
ASM_EX_ARBITER -- requirements
Module: asm_ex_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum WAIT cycles before abort (range 1..255; 8-bit counter).
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  2  level request, bit i from requester i.
REQ-005 din0 / din1  input  4 each  operand of requester 0 / 1.
REQ-006 gnt  output  2  one-hot grant, held for the whole transaction.
REQ-007 done  output  2  one-cycle completion pulse to the granted requester.
REQ-008 err  output  1  one-cycle pulse with done when the transaction timed out.
REQ-009 result  output  7  last captured datapath result.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 asm_start  output  1  start pulse to the asm_ex datapath.
REQ-012 asm_din  output  4  operand to the datapath.
REQ-013 asm_dout  input  7  datapath result.
REQ-014 asm_done_tick  input  1  datapath completion pulse.

Function
REQ-015 The block SHALL implement the Moore FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
REQ-016 IDLE: if req != 0 at an edge, the block SHALL latch the winner's din into asm_din, set gnt, and enter ISSUE; otherwise it SHALL stay in IDLE.
REQ-017 Arbitration SHALL be round-robin: with both bits of req set, the requester not served last wins; with one bit set, that requester wins.
REQ-018 The last-served pointer SHALL update only on entry to DONE.
REQ-019 ISSUE SHALL last exactly one cycle with asm_start=1, clear the timeout counter, and go to WAIT; asm_start SHALL be 0 in all other states.
REQ-020 asm_din SHALL stay stable from ISSUE through DONE, independent of later din0/din1 changes.
REQ-021 WAIT, asm_done_tick=1 at an edge: result SHALL capture asm_dout, and the FSM SHALL go to DONE with err=0.
REQ-022 WAIT, no tick: the counter SHALL increment.
REQ-023 WAIT, counter == TIMEOUT with no tick: the FSM SHALL go to DONE with err=1, and result SHALL be left unchanged.
REQ-024 If asm_done_tick and the timeout coincide, done SHALL win (err=0, result captured).
REQ-025 DONE SHALL last one cycle: done[i]=1 for the granted i, err as decided in WAIT, gnt still asserted; the next state SHALL be IDLE with gnt=0.
REQ-026 Latency SHALL be: req sampled at edge k -> asm_start high after edge k; asm_done_tick sampled at edge m -> done pulse and new result visible after edge m.
REQ-027 Deasserting req mid-transaction SHALL NOT abort; the transaction SHALL complete and pulse done.
REQ-028 asm_done_tick outside WAIT SHALL be ignored, and result SHALL be unchanged.
REQ-029 The earliest re-grant SHALL be the edge after DONE; a req held through DONE SHALL be re-arbitrated in IDLE under REQ-017.

Reset
REQ-030 reset=1 at an edge SHALL force IDLE from any state, mid-transaction included.
REQ-031 reset SHALL clear gnt, done, err, busy, asm_start, asm_din, result (7'h00) and the counter.
REQ-032 reset SHALL set the last-served pointer to 1, so requester 0 wins the first tie.
REQ-033 The aborted transaction SHALL NOT produce a done pulse.

Verification
REQ-034 Single request: req=01, din0=4'h5, model answers asm_dout=7'h19 after 3 WAIT cycles -> one asm_start pulse with asm_din=5, gnt=01 held, then done=01 for 1 cycle, result=7'h19, err=0.
REQ-035 Tie: req=11 from reset -> requester 0 served first; requester 1 served in the next transaction; with req still 11, requester 0 is served third.
REQ-036 Timeout: TIMEOUT=8, model never ticks -> WAIT lasts 9 cycles (counter 0..8), then done=pulse with err=1, result unchanged from its prior value.
REQ-037 Coincident events: tick arrives in the cycle the counter equals TIMEOUT -> err=0, result=asm_dout.
REQ-038 Reset mid-WAIT: assert reset 2 cycles after asm_start -> next cycle all outputs 0, no done pulse; a later stray asm_done_tick is ignored.
REQ-039 Operand stability: change din0 from 4'h3 to 4'hA during WAIT -> asm_din stays 4'h3 until DONE; req dropped in WAIT -> done still pulses.
